// File: rtl/regfile_sb.sv
// Unified integer/FP architectural register file with integrated scoreboard.
// Multi-port combinational reads with optional same-cycle write bypass.
module regfile_sb #(
    parameter int BUS_WIDTH   = 64,
    parameter int REGFILE_LEN = 6,
    parameter int NUM_RD      = 3,
    parameter int NUM_WR      = 2,
    parameter int BYPASS      = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_RD*REGFILE_LEN-1:0] rd_addr,
    output logic [NUM_RD*BUS_WIDTH-1:0]   rd_data,
    output logic [NUM_RD-1:0]             rd_busy,
    input  logic [NUM_WR-1:0]             wr_en,
    input  logic [NUM_WR*REGFILE_LEN-1:0] wr_addr,
    input  logic [NUM_WR*BUS_WIDTH-1:0]   wr_data,
    input  logic                          alloc_en,
    input  logic [REGFILE_LEN-1:0]        alloc_addr,
    output logic                          alloc_stall,
    output logic [REGFILE_LEN:0]          busy_count
);

    localparam int NREG = 2**REGFILE_LEN;

    typedef logic [REGFILE_LEN-1:0] addr_t;
    typedef logic [BUS_WIDTH-1:0]   data_t;

    data_t                regs_q [NREG];
    data_t                regs_d [NREG];
    logic [NREG-1:0]      busy_q;
    logic [NREG-1:0]      busy_d;
    logic [REGFILE_LEN:0] busy_count_q;
    logic [REGFILE_LEN:0] busy_count_d;

    logic [NREG-1:0]      wr_hit;
    logic [NREG-1:0]      alloc_set;
    logic                 alloc_ok;

    logic [NUM_RD-1:0]    rd_hit;
    data_t                rd_fwd [NUM_RD];
    addr_t                rd_a   [NUM_RD];

    // Per-register "written this cycle" vector, shared by scoreboard and stall
    always_comb begin
        wr_hit = '0;
        for (int r = 0; r < NREG; r++) begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_en[i] &&
                    wr_addr[i*REGFILE_LEN +: REGFILE_LEN] == addr_t'(r)) begin
                    wr_hit[r] = 1'b1;
                end
            end
        end
    end

    // Forward candidate per read port; later ports override earlier ones
    always_comb begin
        rd_hit = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            rd_fwd[j] = '0;
            rd_a[j]   = rd_addr[j*REGFILE_LEN +: REGFILE_LEN];
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_en[i] &&
                    wr_addr[i*REGFILE_LEN +: REGFILE_LEN] == rd_a[j]) begin
                    rd_hit[j] = 1'b1;
                    rd_fwd[j] = wr_data[i*BUS_WIDTH +: BUS_WIDTH];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            if (rd_a[j] != '0) begin
                if (BYPASS != 0) begin
                    rd_data[j*BUS_WIDTH +: BUS_WIDTH] =
                        rd_hit[j] ? rd_fwd[j] : regs_q[rd_a[j]];
                    rd_busy[j] = busy_q[rd_a[j]] & ~rd_hit[j];
                end else begin
                    rd_data[j*BUS_WIDTH +: BUS_WIDTH] = regs_q[rd_a[j]];
                    rd_busy[j] = busy_q[rd_a[j]] | rd_hit[j];
                end
            end
        end
    end

    // A write retiring the current owner frees the slot for a new owner
    assign alloc_stall = alloc_en && (alloc_addr != '0) &&
                         busy_q[alloc_addr] && !wr_hit[alloc_addr];

    assign alloc_ok = alloc_en && (alloc_addr != '0) && !alloc_stall;

    always_comb begin
        alloc_set = '0;
        if (alloc_ok) begin
            alloc_set[alloc_addr] = 1'b1;
        end
    end

    always_comb begin
        busy_d    = (busy_q & ~wr_hit) | alloc_set;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        busy_count_d = '0;
        for (int r = 0; r < NREG; r++) begin
            busy_count_d = busy_count_d + (REGFILE_LEN+1)'(busy_d[r]);
        end
    end

    always_comb begin
        regs_d    = regs_q;
        regs_d[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_en[i] &&
                    wr_addr[i*REGFILE_LEN +: REGFILE_LEN] == addr_t'(r)) begin
                    regs_d[r] = wr_data[i*BUS_WIDTH +: BUS_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q       <= '{default: '0};
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign busy_count = busy_count_q;

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Next-generation architectural register file for the core. Holds the unified integer/FP register space: indices 0..31 are x0..x31 and 32..63 are f0..f31 at default size. Compared with the previous block it adds:
- a parametrised number of read and write ports;
- same-cycle write-to-read bypass;
- synchronous reset of all storage;
- an integrated scoreboard with busy bits, WAW allocation stall and a busy count.
It sits between decode/issue (allocation, operand read) and writeback (write ports).

Parameters:
BUS_WIDTH, 64, data width of each register
REGFILE_LEN, 6, address width; 2**REGFILE_LEN registers
NUM_RD, 3, number of read ports (3 covers FMA rs3)
NUM_WR, 2, number of write ports
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
rd_addr  input  NUM_RD*REGFILE_LEN  read addresses, port j at bits [j*REGFILE_LEN +: REGFILE_LEN]
rd_data  output  NUM_RD*BUS_WIDTH  read data, port j at [j*BUS_WIDTH +: BUS_WIDTH]
rd_busy  output  NUM_RD  port j operand not yet available
wr_en  input  NUM_WR  write enable per write port
wr_addr  input  NUM_WR*REGFILE_LEN  write addresses, packed as rd_addr
wr_data  input  NUM_WR*BUS_WIDTH  write data, packed as rd_data
alloc_en  input  1  issue requests ownership of a destination register
alloc_addr  input  REGFILE_LEN  destination register being allocated
alloc_stall  output  1  allocation refused this cycle (WAW hazard)
busy_count  output  REGFILE_LEN+1  number of busy registers

Behaviour:
- Clock and reset:
  - Single clock. rst is sampled at posedge clk only.
  - On reset, all registers clear to 0 and all busy bits clear to 0, so busy_count = 0.
  - While rst is high, write and allocation requests are ignored.
  - Reads stay combinational during reset. After the reset edge, every rd_data = 0, rd_busy = 0 and alloc_stall = 0, except for combinational bypass/hazard terms driven by inputs in the current cycle.
  - Reset mid-operation discards all pending busy state.
- Register 0:
  - Always reads 0, is never written and is never busy.
  - wr_en or alloc_en targeting address 0 has no effect and never stalls.
  - Only address 0 is hardwired; address 32 (f0) is an ordinary register.
- Writes:
  - Take effect at posedge clk when wr_en[i] = 1 and wr_addr[i] != 0.
  - If two or more ports write the same address in one cycle, the highest-index port wins.
  - Different addresses are written in parallel.
- Reads are combinational, zero latency. For each port j:
  - rd_addr = 0 returns 0;
  - else, if BYPASS = 1 and any enabled write port targets rd_addr, returns that port's wr_data (highest index wins);
  - else returns the stored value.
- Scoreboard, one busy bit per register:
  - Set at posedge when alloc_en = 1, alloc_addr != 0 and alloc_stall = 0.
  - Cleared at posedge when any enabled write port targets that address.
  - Allocation and write to the same address in one cycle: the data is written and the busy bit ends at 1 (the new owner wins).
- rd_busy[j]:
  - rd_addr = 0: 0.
  - BYPASS = 1: busy[rd_addr] AND NOT (same-cycle write match), i.e. a forwarded value counts as available.
  - BYPASS = 0: busy[rd_addr] OR (same-cycle write match).
- alloc_stall = alloc_en AND alloc_addr != 0 AND busy[alloc_addr] AND NOT (same-cycle write to alloc_addr). A stalled allocation changes no state; issue must hold and retry.
- busy_count:
  - Registered population count of busy bits, updated on the same edge as the busy bits.
  - Maximum value 2**REGFILE_LEN - 1.
- No X may propagate from unwritten registers, since reset clears all storage.

Test Plan:
- Reset then read ports 0..2 at addresses 5, 33, 63 -> rd_data = 0, rd_busy = 0, busy_count = 0.
- Write port 0: addr 7 = 0xDEAD; in the same cycle read addr 7 -> BYPASS=1 gives 0xDEAD combinationally, BYPASS=0 gives 0 and rd_busy = 1; next cycle both give 0xDEAD. Write addr 0 = 0xFFFF -> reads 0.
- Ports 0 and 1 both write addr 12 (0x1111, 0x2222) -> next-cycle read = 0x2222; the same-cycle bypass also gives 0x2222.
- Allocate addr 9 -> busy_count = 1, a read of 9 shows rd_busy = 1. Allocate 9 again -> alloc_stall = 1 and busy_count stays 1. Write 9 = 0x55 -> busy clears and busy_count = 0.
- Same cycle: alloc addr 20 while busy[20] = 1 and port 1 writes addr 20 = 0xAB -> alloc_stall = 0, data = 0xAB, busy[20] stays 1, busy_count unchanged.
- Allocate addrs 3, 4 and 40 over 3 cycles (busy_count = 3), assert rst for one cycle -> busy_count = 0, reads of 3/4/40 = 0, rd_busy = 0.
